// File: rtl/press_classifier.sv
// press_classifier: classifies debounced button presses as short, long or double and counts rising edges.
module press_classifier #(
    parameter int LONG_CNT = 16,
    parameter int DBL_WIN  = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       db,
    output logic       rise_p,
    output logic       short_p,
    output logic       long_p,
    output logic       dbl_p,
    output logic [7:0] press_cnt
);
    typedef enum logic [2:0] {IDLE, HELD, LONG_HELD, WAIT2, HELD2} state_t;
    localparam logic [7:0] LONG_MAX = 8'(LONG_CNT - 1);
    localparam logic [7:0] DBL_MAX  = 8'(DBL_WIN - 1);
    state_t     r_state, w_state_n;
    logic [7:0] r_timer, w_timer_n;
    logic       r_db_q;
    logic       w_rise_e, w_rise_p, w_short, w_long, w_dbl;
    assign w_rise_e = db & ~r_db_q;
    always_comb begin
        w_state_n = r_state;
        w_timer_n = r_timer;
        w_rise_p  = 1'b0;
        w_short   = 1'b0;
        w_long    = 1'b0;
        w_dbl     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_rise_e) begin
                    w_state_n = HELD;
                    w_timer_n = 8'd0;
                    w_rise_p  = 1'b1;
                end
            end
            HELD: begin
                if (!db) begin
                    w_state_n = WAIT2;
                    w_timer_n = 8'd0;
                end else if (r_timer == LONG_MAX) begin
                    w_state_n = LONG_HELD;
                    w_long    = 1'b1;
                end else
                    w_timer_n = r_timer + 8'd1;
            end
            LONG_HELD: w_state_n = db ? LONG_HELD : IDLE;
            WAIT2: begin
                if (db) begin
                    w_state_n = HELD2;
                    w_dbl     = 1'b1;
                    w_rise_p  = 1'b1;
                end else if (r_timer == DBL_MAX) begin
                    w_state_n = IDLE;
                    w_short   = 1'b1;
                end else
                    w_timer_n = r_timer + 8'd1;
            end
            HELD2: w_state_n = db ? HELD2 : IDLE;
            default: w_state_n = IDLE;
        endcase
    end
    // db_q resets high so a button held through reset release is not a press
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_timer   <= 8'd0;
            r_db_q    <= 1'b1;
            press_cnt <= 8'd0;
            rise_p    <= 1'b0;
            short_p   <= 1'b0;
            long_p    <= 1'b0;
            dbl_p     <= 1'b0;
        end else begin
            r_state   <= w_state_n;
            r_timer   <= w_timer_n;
            r_db_q    <= db;
            press_cnt <= (w_rise_e && press_cnt != 8'hFF) ? press_cnt + 8'd1 : press_cnt;
            rise_p    <= w_rise_p;
            short_p   <= w_short;
            long_p    <= w_long;
            dbl_p     <= w_dbl;
        end
    end
endmodule
